// File: rtl/adxl362_spi_if.sv
// adxl362_spi_if: four-wire SPI bus between an ADXL362 master and responder.
// The master drives sclk/cs/mosi; the responder drives miso.
interface adxl362_spi_if;
   logic sclk;
   logic cs;
   logic mosi;
   logic miso;

   modport master (output sclk, output cs, output mosi, input miso);
   modport slave  (input sclk, input cs, input mosi, output miso);
endinterface

// File: rtl/adxl362_spi_slave.sv
// adxl362_spi_slave: oversampled SPI responder emulating the ADXL362 register map.
// Define ADXL362_SLV_WRITE_EN to store/read back the writable regs 0x1F-0x2E.
module adxl362_spi_slave #(
   parameter bit p_cpol = 1'b0,
   parameter bit p_cpha = 1'b0
) (
   input  logic         clk_i,
   input  logic         rst_i,
   adxl362_spi_if.slave spi,
   input  logic [15:0]  ax_i,
   input  logic [15:0]  ay_i,
   input  logic [15:0]  az_i,
   input  logic         sample_i,
   output logic         reg_wr_o,
   output logic [7:0]   reg_addr_o,
   output logic [7:0]   reg_data_o,
   output logic         busy_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_DATA, S_IGNORE
   } state_e;

   localparam bit SampleRise = (p_cpol == p_cpha);

   state_e      state_q, state_d;
   logic [1:0]  sclk_sq, cs_sq, mosi_sq;
   logic        sclk_prev_q, cs_prev_q;
   logic        sclk_s, cs_s, mosi_s;
   logic        sclk_rise, sclk_fall;
   logic        samp_edge, shift_edge;
   logic        cs_rise, cs_fall, byte_done;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  rx_q, rx_d, rx_byte;
   logic [7:0]  addr_q, addr_d;
   logic        rd_q, rd_d;
   logic [7:0]  tx_q, tx_d;
   logic        miso_q, miso_d;
   logic        wr_q, wr_d;
   logic [7:0]  waddr_q, waddr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        hit_q, hit_d;
   logic [15:0] ax_q, ay_q, az_q;
   logic        drdy_q, pend_q;
   logic [7:0]  rd_addr, rd_data;

   // No reset on the synchronizers: a reset with cs held low must not
   // later look like a cs falling edge and restart a half-seen transfer.
   always_ff @(posedge clk_i) begin
      sclk_sq     <= {sclk_sq[0], spi.sclk};
      cs_sq       <= {cs_sq[0], spi.cs};
      mosi_sq     <= {mosi_sq[0], spi.mosi};
      sclk_prev_q <= sclk_sq[1];
      cs_prev_q   <= cs_sq[1];
   end

   assign sclk_s     = sclk_sq[1];
   assign cs_s       = cs_sq[1];
   assign mosi_s     = mosi_sq[1];
   assign sclk_rise  = sclk_s & ~sclk_prev_q & ~cs_s;
   assign sclk_fall  = ~sclk_s & sclk_prev_q & ~cs_s;
   assign samp_edge  = SampleRise ? sclk_rise : sclk_fall;
   assign shift_edge = SampleRise ? sclk_fall : sclk_rise;
   assign cs_rise    = cs_s & ~cs_prev_q;
   assign cs_fall    = ~cs_s & cs_prev_q;
   assign rx_byte    = {rx_q[6:0], mosi_s};
   assign byte_done  = samp_edge & (bit_q == 3'd7) & (state_q != S_IDLE);

`ifdef ADXL362_SLV_WRITE_EN
   logic [7:0] wregs_q [16];
   logic [3:0] rd_idx, wr_idx;
   assign rd_idx = 4'(rd_addr - 8'h1F);
   assign wr_idx = 4'(waddr_q - 8'h1F);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wregs_q <= '{default: 8'h00};
      end else if (wr_q && waddr_q >= 8'h1F && waddr_q <= 8'h2E) begin
         if (waddr_q == 8'h1F && wdata_q == 8'h52)
            wregs_q <= '{default: 8'h00};
         else
            wregs_q[wr_idx] <= wdata_q;
      end
   end
`endif

   assign rd_addr = (state_q == S_ADDR) ? rx_byte : addr_q + 8'd1;

   always_comb begin
      rd_data = 8'h00;
      unique case (rd_addr)
         8'h00:   rd_data = 8'hAD;
         8'h01:   rd_data = 8'h1D;
         8'h02:   rd_data = 8'hF2;
         8'h03:   rd_data = 8'h01;
         8'h0B:   rd_data = {7'b0, drdy_q};
         8'h0E:   rd_data = ax_q[7:0];
         8'h0F:   rd_data = ax_q[15:8];
         8'h10:   rd_data = ay_q[7:0];
         8'h11:   rd_data = ay_q[15:8];
         8'h12:   rd_data = az_q[7:0];
         8'h13:   rd_data = az_q[15:8];
         default: begin
`ifdef ADXL362_SLV_WRITE_EN
            if (rd_addr >= 8'h1F && rd_addr <= 8'h2E)
               rd_data = wregs_q[rd_idx];
`endif
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      rx_d    = rx_q;
      addr_d  = addr_q;
      rd_d    = rd_q;
      tx_d    = tx_q;
      miso_d  = miso_q;
      wr_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      hit_d   = hit_q;
      if (cs_rise) begin
         state_d = S_IDLE;
         miso_d  = 1'b0;
      end else if (cs_fall) begin
         state_d = S_CMD;
         bit_d   = 3'd0;
         rd_d    = 1'b0;
         hit_d   = 1'b0;
         miso_d  = 1'b0;
      end else if (state_q != S_IDLE) begin
         if (samp_edge) begin
            rx_d  = rx_byte;
            bit_d = bit_q + 3'd1;
         end
         // In cpha=0 the MSB is already out at the byte boundary.
         if (shift_edge && state_q == S_DATA && rd_q &&
             (p_cpha || bit_q != 3'd0)) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
         end
         if (byte_done) begin
            unique case (state_q)
               S_CMD: begin
                  if (rx_byte == 8'h0A || rx_byte == 8'h0B) begin
                     state_d = S_ADDR;
                     rd_d    = rx_byte[0];
                  end else begin
                     state_d = S_IGNORE;
                  end
               end
               S_ADDR: begin
                  state_d = S_DATA;
                  addr_d  = rx_byte;
               end
               S_DATA: begin
                  addr_d = addr_q + 8'd1;
                  if (rd_q) begin
                     if (addr_q >= 8'h0E && addr_q <= 8'h13)
                        hit_d = 1'b1;
                  end else begin
                     wr_d    = 1'b1;
                     waddr_d = addr_q;
                     wdata_d = rx_byte;
                  end
               end
               default: ;
            endcase
            if (rd_q && (state_q == S_ADDR || state_q == S_DATA)) begin
               if (p_cpha) begin
                  tx_d = rd_data;
               end else begin
                  miso_d = rd_data[7];
                  tx_d   = {rd_data[6:0], 1'b0};
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         bit_q   <= 3'd0;
         rx_q    <= 8'h00;
         addr_q  <= 8'h00;
         rd_q    <= 1'b0;
         tx_q    <= 8'h00;
         miso_q  <= 1'b0;
         wr_q    <= 1'b0;
         waddr_q <= 8'h00;
         wdata_q <= 8'h00;
         hit_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         rx_q    <= rx_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         tx_q    <= tx_d;
         miso_q  <= miso_d;
         wr_q    <= wr_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         hit_q   <= hit_d;
      end
   end

   // Shadows only change while cs is high; a pending load wins over a clear.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ax_q   <= 16'h0000;
         ay_q   <= 16'h0000;
         az_q   <= 16'h0000;
         drdy_q <= 1'b0;
         pend_q <= 1'b0;
      end else if (cs_s) begin
         if (sample_i || (cs_rise && pend_q)) begin
            ax_q   <= ax_i;
            ay_q   <= ay_i;
            az_q   <= az_i;
            drdy_q <= 1'b1;
            pend_q <= 1'b0;
         end else if (cs_rise && hit_q) begin
            drdy_q <= 1'b0;
         end
      end else if (sample_i) begin
         pend_q <= 1'b1;
      end
   end

   assign spi.miso   = miso_q;
   assign reg_wr_o   = wr_q;
   assign reg_addr_o = waddr_q;
   assign reg_data_o = wdata_q;
   assign busy_o     = ~cs_s & ~rst_i;

endmodule

// File: tb/tb_adxl362_spi_slave.sv
// tb_adxl362_spi_slave: directed SPI bursts against four responders,
// one per cpol/cpha mode; instance 0 (mode 0) carries most of the tests.
module tb_adxl362_spi_slave;

   localparam time H = 80ns;

`ifdef ADXL362_SLV_WRITE_EN
   localparam logic [7:0] Exp2D = 8'h02;
`else
   localparam logic [7:0] Exp2D = 8'h00;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  sclk_v, cs_v, mosi_v;
   wire  [3:0]  miso_v;
   logic [15:0] ax, ay, az;
   logic        sample;
   wire  [3:0]  wr_v, busy_v;
   wire  [7:0]  raddr_v [4];
   wire  [7:0]  rdata_v [4];

   logic [7:0]  txb [24];
   logic [7:0]  rxb [24];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          wr_cnt = 0;
   logic [7:0]  last_a, last_d;
   logic        miso_hi;

   always #5ns clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam bit Cpol = (g / 2) != 0;
      localparam bit Cpha = (g % 2) != 0;
      adxl362_spi_if bus ();
      assign bus.sclk  = sclk_v[g];
      assign bus.cs    = cs_v[g];
      assign bus.mosi  = mosi_v[g];
      assign miso_v[g] = bus.miso;
      adxl362_spi_slave #(.p_cpol(Cpol), .p_cpha(Cpha)) u_dut (
         .clk_i      (clk),
         .rst_i      (rst),
         .spi        (bus),
         .ax_i       (ax),
         .ay_i       (ay),
         .az_i       (az),
         .sample_i   (sample),
         .reg_wr_o   (wr_v[g]),
         .reg_addr_o (raddr_v[g]),
         .reg_data_o (rdata_v[g]),
         .busy_o     (busy_v[g])
      );
   end

   always @(negedge clk) begin
      if (wr_v[0]) begin
         wr_cnt = wr_cnt + 1;
         last_a = raddr_v[0];
         last_d = rdata_v[0];
      end
      if (miso_v[0]) miso_hi = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   task automatic clr_tx();
      foreach (txb[j]) txb[j] = 8'h00;
   endtask

   // Drives nb bits from txb and captures miso into rxb.
   task automatic burst(input int m, input int nb);
      bit cpol, cpha;
      cpol = (m / 2) != 0;
      cpha = (m % 2) != 0;
      foreach (rxb[j]) rxb[j] = 8'h00;
      @(negedge clk);
      cs_v[m] = 1'b0;
      #(H);
      for (int k = 0; k < nb; k++) begin
         if (!cpha) begin
            mosi_v[m] = txb[k / 8][7 - k % 8];
            #(H);
            sclk_v[m] = ~cpol;
            rxb[k / 8][7 - k % 8] = miso_v[m];
            #(H);
            sclk_v[m] = cpol;
         end else begin
            sclk_v[m] = ~cpol;
            mosi_v[m] = txb[k / 8][7 - k % 8];
            #(H);
            sclk_v[m] = cpol;
            rxb[k / 8][7 - k % 8] = miso_v[m];
            #(H);
         end
      end
      #(H);
      cs_v[m]   = 1'b1;
      mosi_v[m] = 1'b0;
      #(2 * H);
   endtask

   task automatic read1(input logic [7:0] a);
      clr_tx();
      txb[0] = 8'h0B;
      txb[1] = a;
      burst(0, 24);
   endtask

   task automatic pulse_sample(input logic [15:0] x, y, z);
      @(negedge clk);
      ax = x;
      ay = y;
      az = z;
      sample = 1'b1;
      @(negedge clk);
      sample = 1'b0;
   endtask

   initial begin
      int w0;
      rst    = 1'b1;
      sclk_v = 4'b1100;
      cs_v   = 4'hF;
      mosi_v = 4'h0;
      ax     = 16'h0;
      ay     = 16'h0;
      az     = 16'h0;
      sample = 1'b0;
      miso_hi = 1'b0;
      repeat (6) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      check("rst_miso", miso_v, 4'h0);
      check("rst_wr", wr_v, 4'h0);
      check("rst_busy", busy_v, 4'h0);
      check("rst_addr", raddr_v[0], 8'h00);
      check("rst_data", rdata_v[0], 8'h00);

      clr_tx();
      txb[0] = 8'h0B;
      burst(0, 48);
      check("id0", rxb[2], 8'hAD);
      check("id1", rxb[3], 8'h1D);
      check("id2", rxb[4], 8'hF2);
      check("id3", rxb[5], 8'h01);

      pulse_sample(16'hA2A1, 16'hA4A3, 16'hA6A5);
      read1(8'h0B);
      check("status_pre", rxb[2], 8'h01);
      clr_tx();
      txb[0] = 8'h0B;
      txb[1] = 8'h0E;
      burst(0, 64);
      for (int i = 0; i < 6; i++)
         check($sformatf("xyz%0d", i), rxb[2 + i], 8'hA1 + 8'(i));
      read1(8'h0B);
      check("status_post", rxb[2], 8'h00);

      pulse_sample(16'h2222, 16'h2222, 16'h2222);
      clr_tx();
      txb[0] = 8'h0B;
      txb[1] = 8'h0E;
      fork
         burst(0, 64);
         begin
            #(3000ns);
            check("busy_mid", busy_v[0], 1'b1);
            pulse_sample(16'h1111, 16'h1111, 16'h1111);
         end
      join
      for (int i = 0; i < 6; i++)
         check($sformatf("old%0d", i), rxb[2 + i], 8'h22);
      read1(8'h0B);
      check("status_pend", rxb[2], 8'h01);
      clr_tx();
      txb[0] = 8'h0B;
      txb[1] = 8'h0E;
      burst(0, 64);
      check("new0", rxb[2], 8'h11);
      check("new5", rxb[7], 8'h11);

      w0 = wr_cnt;
      miso_hi = 1'b0;
      clr_tx();
      txb[0] = 8'h0A;
      txb[1] = 8'h2D;
      txb[2] = 8'h02;
      burst(0, 24);
      check("wr_cnt", wr_cnt - w0, 1);
      check("wr_addr", last_a, 8'h2D);
      check("wr_data", last_d, 8'h02);
      check("wr_miso", miso_hi, 1'b0);
      read1(8'h2D);
      check("rb_2d", rxb[2], Exp2D);

      w0 = wr_cnt;
      miso_hi = 1'b0;
      clr_tx();
      txb[0] = 8'h0D;
      txb[1] = 8'h0A;
      txb[2] = 8'h2D;
      txb[3] = 8'hFF;
      burst(0, 32);
      check("ign_miso", miso_hi, 1'b0);
      check("ign_wr", wr_cnt - w0, 0);
      read1(8'h00);
      check("ign_next", rxb[2], 8'hAD);

      w0 = wr_cnt;
      clr_tx();
      txb[0] = 8'h0A;
      txb[1] = 8'h2D;
      txb[2] = 8'hFF;
      burst(0, 21);
      check("part_wr", wr_cnt - w0, 0);
      check("part_busy", busy_v[0], 1'b0);
      read1(8'h2D);
      check("part_rb", rxb[2], Exp2D);

      clr_tx();
      txb[0] = 8'h0A;
      txb[1] = 8'h1F;
      txb[2] = 8'h52;
      burst(0, 24);
      clr_tx();
      txb[0] = 8'h0B;
      txb[1] = 8'h1F;
      burst(0, 17 * 8);
      check("srst_1f", rxb[2], 8'h00);
      check("srst_2d", rxb[16], 8'h00);

      for (int m = 1; m < 4; m++) begin
         clr_tx();
         txb[0] = 8'h0B;
         burst(m, 48);
         check($sformatf("m%0d_id0", m), rxb[2], 8'hAD);
         check($sformatf("m%0d_id1", m), rxb[3], 8'h1D);
         check($sformatf("m%0d_id2", m), rxb[4], 8'hF2);
         check($sformatf("m%0d_id3", m), rxb[5], 8'h01);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
